// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_run_ctrl
//  Purpose  : Run/step sequencer for the RISC-V core. Synchronizes and
//             debounces the run switch and step button, holds the core in
//             reset after system reset, gates the core with a clock enable
//             for free-run / halt / single-step, counts cycles and retired
//             instructions, and drives the registered DATA/LED display.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
    parameter int DEB_CYCLES   = 4,
    parameter int RST_HOLD     = 4,
    parameter int STEP_TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CPU_RUN,
    input  logic        CPU_DEBUG,
    input  logic [6:0]  DIP,
    input  logic        RETIRE,
    input  logic [31:0] PC,
    input  logic [31:0] INSTR,
    output logic        CORE_RST,
    output logic        CORE_EN,
    output logic [1:0]  STATE,
    output logic [31:0] DATA,
    output logic [15:0] LED
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int STEP_W = $clog2(STEP_TIMEOUT + 1);
    localparam int N_IN   = 2;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_HALT = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } state_t;

    // Bit 0 = run switch, bit 1 = step button.
    logic [N_IN-1:0] w_raw;
    logic [N_IN-1:0] w_deb;

    assign w_raw = {CPU_DEBUG, CPU_RUN};

    // ------------------------------------------------------------------
    // Per-input two-flop synchronizer followed by a stability debouncer.
    // The debounced value only follows the synced value after they have
    // differed for DEB_CYCLES consecutive cycles; any agreement restarts
    // the count, so short glitches are swallowed.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
            logic             sync1_q;
            logic             sync2_q;
            logic             deb_q;
            logic             deb_d;
            logic [DEB_W-1:0] cnt_q;
            logic [DEB_W-1:0] cnt_d;

            // Debounce counter / output update decision.
            always_comb begin
                deb_d = deb_q;
                cnt_d = '0;
                if (sync2_q != deb_q) begin
                    if (cnt_q == DEB_W'(DEB_CYCLES)) begin
                        deb_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            // Synchronizer and debounce registers.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    deb_q   <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= w_raw[gi];
                    sync2_q <= sync1_q;
                    deb_q   <= deb_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign w_deb[gi] = deb_q;
        end
    endgenerate

    logic w_run_d;
    logic w_step_pulse;
    logic dbg_prev_q;

    assign w_run_d      = w_deb[0];
    assign w_step_pulse = w_deb[1] & ~dbg_prev_q;

    // ------------------------------------------------------------------
    // Sequencer state and counters.
    // ------------------------------------------------------------------
    state_t            state_q,    state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic              timeout_q,  timeout_d;
    logic [31:0]       cyc_cnt_q,  cyc_cnt_d;
    logic [31:0]       ret_cnt_q,  ret_cnt_d;
    logic [31:0]       data_q,     data_d;
    logic [15:0]       led_q,      led_d;
    logic [1:0]        w_state;
    logic              w_core_en;
    logic              w_unused_dip;

    assign w_state      = state_q;
    assign w_core_en    = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign w_unused_dip = ^DIP[6:3];

    // Next-state logic; RUN has priority over a step request in HALT and
    // the run switch is ignored until an in-flight step finishes.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        step_cnt_d = step_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_W'(RST_HOLD)) begin
                    state_d    = w_run_d ? ST_RUN : ST_HALT;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_HALT: begin
                if (w_run_d) begin
                    state_d = ST_RUN;
                end else if (w_step_pulse) begin
                    state_d    = ST_STEP;
                    step_cnt_d = '0;
                    timeout_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (!w_run_d) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                if (RETIRE) begin
                    state_d = ST_HALT;
                end else if (step_cnt_q == STEP_W'(STEP_TIMEOUT - 1)) begin
                    state_d   = ST_HALT;
                    timeout_d = 1'b1;
                end else begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    // Cycle / retire counters; held at zero while the core is in reset.
    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        ret_cnt_d = ret_cnt_q;
        if (state_q == ST_HOLD) begin
            cyc_cnt_d = '0;
            ret_cnt_d = '0;
        end else if (w_core_en) begin
            cyc_cnt_d = cyc_cnt_q + 32'd1;
            if (RETIRE) begin
                ret_cnt_d = ret_cnt_q + 32'd1;
            end
        end
    end

    // Display word and status LEDs, registered one cycle behind sources.
    always_comb begin
        data_d = 32'd0;
        case (DIP[2:0])
            3'd0:    data_d = PC;
            3'd1:    data_d = INSTR;
            3'd2:    data_d = cyc_cnt_q;
            3'd3:    data_d = ret_cnt_q;
            3'd4:    data_d = {30'd0, w_state};
            default: data_d = 32'd0;
        endcase
        led_d = {ret_cnt_q[11:0], w_run_d, timeout_q, w_state};
    end

    // All sequencer, counter and display registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            step_cnt_q <= '0;
            timeout_q  <= 1'b0;
            cyc_cnt_q  <= '0;
            ret_cnt_q  <= '0;
            data_q     <= '0;
            led_q      <= '0;
            dbg_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            step_cnt_q <= step_cnt_d;
            timeout_q  <= timeout_d;
            cyc_cnt_q  <= cyc_cnt_d;
            ret_cnt_q  <= ret_cnt_d;
            data_q     <= data_d;
            led_q      <= led_d;
            dbg_prev_q <= w_deb[1];
        end
    end

    assign CORE_RST = (state_q == ST_HOLD);
    assign CORE_EN  = w_core_en;
    assign STATE    = w_state;
    assign DATA     = data_q;
    assign LED      = led_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_run_ctrl
//  Purpose  : Self-checking bench for cpu_run_ctrl: directed scenarios plus
//             randomized segments, checked against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 4;
    localparam int TMO  = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CPU_RUN;
    logic        CPU_DEBUG;
    logic [6:0]  DIP;
    logic        RETIRE;
    logic [31:0] PC;
    logic [31:0] INSTR;
    logic        CORE_RST;
    logic        CORE_EN;
    logic [1:0]  STATE;
    logic [31:0] DATA;
    logic [15:0] LED;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    cpu_run_ctrl #(
        .DEB_CYCLES  (DEB),
        .RST_HOLD    (HOLD),
        .STEP_TIMEOUT(TMO)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .CPU_RUN  (CPU_RUN),
        .CPU_DEBUG(CPU_DEBUG),
        .DIP      (DIP),
        .RETIRE   (RETIRE),
        .PC       (PC),
        .INSTR    (INSTR),
        .CORE_RST (CORE_RST),
        .CORE_EN  (CORE_EN),
        .STATE    (STATE),
        .DATA     (DATA),
        .LED      (LED)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. The synced view of a raw input is simply the raw
    // value seen two edges earlier; a debounced input flips on the
    // (DEB+1)-th consecutive edge at which the synced view disagrees.
    // ------------------------------------------------------------------
    int          m_st;        // 0 HOLD, 1 HALT, 2 RUN, 3 STEP
    int          m_since;     // edges since reset released
    int          m_step_age;  // enabled cycles already spent in this step
    bit          m_tmo;
    logic [31:0] m_cyc, m_ret, m_data;
    logic [15:0] m_led;
    bit          q_run[$];
    bit          q_dbg[$];
    bit          deb_run, deb_dbg, deb_dbg_prev;
    int          streak_run, streak_dbg;

    task automatic deb_step(inout bit deb, inout int streak, input bit s);
        if (s != deb) begin
            streak++;
            if (streak == DEB + 1) begin
                deb    = s;
                streak = 0;
            end
        end else begin
            streak = 0;
        end
    endtask

    task automatic model_edge();
        bit pulse;
        bit en;
        bit sr;
        bit sd;
        if (RST) begin
            m_st = 0; m_since = 0; m_step_age = 0; m_tmo = 0;
            m_cyc = 0; m_ret = 0; m_data = 0; m_led = 0;
            q_run = {}; q_dbg = {};
            q_run.push_back(1'b0); q_run.push_back(1'b0);
            q_dbg.push_back(1'b0); q_dbg.push_back(1'b0);
            deb_run = 0; deb_dbg = 0; deb_dbg_prev = 0;
            streak_run = 0; streak_dbg = 0;
            return;
        end
        pulse = deb_dbg && !deb_dbg_prev;
        en    = (m_st == 2) || (m_st == 3);
        case (DIP[2:0])
            3'd0:    m_data = PC;
            3'd1:    m_data = INSTR;
            3'd2:    m_data = m_cyc;
            3'd3:    m_data = m_ret;
            3'd4:    m_data = 32'(m_st);
            default: m_data = 32'd0;
        endcase
        m_led = {m_ret[11:0], deb_run, m_tmo, 2'(m_st)};
        if (m_st == 0) begin
            m_cyc = 0;
            m_ret = 0;
        end else if (en) begin
            m_cyc = m_cyc + 1;
            if (RETIRE) m_ret = m_ret + 1;
        end
        m_since++;
        case (m_st)
            0: if (m_since == HOLD + 1) m_st = deb_run ? 2 : 1;
            1: begin
                if (deb_run) m_st = 2;
                else if (pulse) begin
                    m_st = 3; m_step_age = 0; m_tmo = 0;
                end
            end
            2: if (!deb_run) m_st = 1;
            default: begin
                if (RETIRE) m_st = 1;
                else if (m_step_age + 1 == TMO) begin
                    m_st = 1; m_tmo = 1;
                end else m_step_age++;
            end
        endcase
        sr = q_run.pop_front(); q_run.push_back(CPU_RUN);
        sd = q_dbg.pop_front(); q_dbg.push_back(CPU_DEBUG);
        deb_step(deb_run, streak_run, sr);
        deb_dbg_prev = deb_dbg;
        deb_step(deb_dbg, streak_dbg, sd);
    endtask

    // One clock: drive inputs, advance DUT and model, compare just after.
    task automatic cycle(input bit rst, input bit run, input bit dbg,
                         input bit ret, input logic [6:0] dip);
        RST = rst; CPU_RUN = run; CPU_DEBUG = dbg; RETIRE = ret; DIP = dip;
        PC = $urandom; INSTR = $urandom;
        @(posedge CLK);
        model_edge();
        #1;
        check("core_rst", 32'(CORE_RST), 32'(m_st == 0));
        check("core_en",  32'(CORE_EN),  32'((m_st == 2) || (m_st == 3)));
        check("state",    32'(STATE),    32'(m_st));
        check("data",     DATA,          m_data);
        check("led",      32'(LED),      32'(m_led));
    endtask

    initial begin
        int n_hold;
        int k;
        int en_cnt;
        bit ret;
        bit rst;
        bit run;
        bit dbg;
        int len;
        int rmode;
        logic [6:0] dip;

        // Reset with the run switch already on.
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 7'd3);
        check("rst_core_rst", 32'(CORE_RST), 32'd1);
        check("rst_core_en",  32'(CORE_EN),  32'd0);
        check("rst_state",    32'(STATE),    32'd0);
        check("rst_data",     DATA,          32'd0);
        check("rst_led",      32'(LED),      32'd0);

        // Hold length and run latency after release.
        n_hold = 0; k = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle(0, 1, 0, 0, 7'd3);
            if (CORE_RST) n_hold++;
            if (STATE == 2'd2) begin
                k = i;
                break;
            end
        end
        check("hold_len", 32'(n_hold), 32'(HOLD));
        check("run_latency", 32'(k), 32'(DEB + 4));

        // Free run with RETIRE on for 20 enabled cycles.
        for (int i = 0; i < 20; i++) cycle(0, 1, 0, 1, 7'd3);
        cycle(0, 0, 0, 0, 7'd3);
        check("free_ret_data", DATA, 32'd20);
        check("free_ret_led", 32'(LED[15:4]), 32'd20);
        for (int i = 0; i < 15; i++) cycle(0, 0, 0, 0, 7'd2);
        check("halt_after_run", 32'(STATE), 32'd1);

        // Single step, retire on the third enabled cycle, button held 10.
        en_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (CORE_EN) en_cnt++;
            ret = CORE_EN && (en_cnt == 3);
            cycle(0, 0, i < 10, ret, 7'd3);
        end
        check("step_len", 32'(en_cnt), 32'd3);
        check("step_back_halt", 32'(STATE), 32'd1);

        // Step with no retire: aborted after TMO enabled cycles.
        en_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (CORE_EN) en_cnt++;
            cycle(0, 0, i < 10, 0, 7'd3);
        end
        check("timeout_len", 32'(en_cnt), 32'(TMO));
        check("timeout_led", 32'(LED[2]), 32'd1);

        // Next step clears the timeout flag.
        en_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (CORE_EN) en_cnt++;
            cycle(0, 0, i < 10, CORE_EN, 7'd3);
        end
        check("step1_len", 32'(en_cnt), 32'd1);
        check("timeout_clr", 32'(LED[2]), 32'd0);

        // Glitches shorter than the debounce window.
        en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (CORE_EN) en_cnt++;
            cycle(0, 0, i < 3, 0, 7'd4);
        end
        check("dbg_glitch", 32'(en_cnt), 32'd0);
        en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (CORE_EN) en_cnt++;
            cycle(0, i < 3, 0, 0, 7'd4);
        end
        check("run_glitch", 32'(en_cnt), 32'd0);

        // Run and step arriving together: run wins.
        for (int i = 0; i < 15; i++) cycle(0, 1, i < 10, 0, 7'd4);
        check("run_beats_step", 32'(STATE), 32'd2);

        // Reset during free run.
        for (int i = 0; i < 50; i++) cycle(0, 1, 0, i[0], 7'd2);
        cycle(1, 1, 0, 0, 7'd2);
        check("midrst_state", 32'(STATE), 32'd0);
        check("midrst_core_en", 32'(CORE_EN), 32'd0);
        check("midrst_core_rst", 32'(CORE_RST), 32'd1);
        cycle(0, 1, 0, 0, 7'd2);
        check("midrst_data", DATA, 32'd0);

        // Randomized segments.
        for (int seg = 0; seg < 150; seg++) begin
            len   = $urandom_range(1, 30);
            run   = 1'($urandom_range(0, 1));
            dbg   = 1'($urandom_range(0, 1));
            rmode = $urandom_range(0, 3);
            dip   = 7'($urandom);
            for (int i = 0; i < len; i++) begin
                case (rmode)
                    0:       ret = 1'b0;
                    1:       ret = ($urandom_range(0, 9) == 0);
                    2:       ret = 1'($urandom_range(0, 1));
                    default: ret = 1'b1;
                endcase
                rst = ($urandom_range(0, 399) == 0);
                cycle(rst, run, dbg, ret, dip);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
